// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: controller state encodings and the
// one-hot phase-done flags exchanged between the FSM and the phase timer.
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'b000,
        FillingWater = 3'b001,
        Washing      = 3'b010,
        Rinsing      = 3'b011,
        Spinning     = 3'b100
    } wm_state_e;

    localparam logic [3:0] Done_None         = 4'b0000;
    localparam logic [3:0] Done_FillingWater = 4'b1000;
    localparam logic [3:0] Done_Washing      = 4'b0100;
    localparam logic [3:0] Done_Rinsing      = 4'b0010;
    localparam logic [3:0] Done_Spinning     = 4'b0001;

    // Largest of the four phase durations, used to size counters.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Done flag belonging to a timed phase; untimed states map to no flag.
    function automatic logic [3:0] done_flag(input logic [2:0] st);
        logic [3:0] f;
        case (st)
            FillingWater: f = Done_FillingWater;
            Washing:      f = Done_Washing;
            Rinsing:      f = Done_Rinsing;
            Spinning:     f = Done_Spinning;
            default:      f = Done_None;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase timer for the washing-machine controller. Counts non-paused cycles
// in each timed phase and raises a one-cycle one-hot DoneFlags pulse when
// the phase duration elapses. Also reports cycles remaining for a display.
module wash_phase_timer
    import wm_pkg::*;
#(
    parameter int FILL_CYCLES  = 16,
    parameter int WASH_CYCLES  = 32,
    parameter int RINSE_CYCLES = 24,
    parameter int SPIN_CYCLES  = 20,
    parameter int CW = $clog2(max_of4(FILL_CYCLES, WASH_CYCLES, RINSE_CYCLES, SPIN_CYCLES) + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [2:0]    current_state,
    input  logic          Pause,
    output logic [3:0]    DoneFlags,
    output logic [CW-1:0] Remaining
);

    logic [2:0]    prev_state_r;
    logic [CW-1:0] cnt_r;
    logic          fired_r;

    logic          timed_s;
    logic [CW-1:0] dur_s;
    logic          new_phase_s;
    logic          tick_s;
    logic          hit_s;
    logic [CW-1:0] base_cnt_s;
    logic [CW-1:0] cnt_next_s;
    logic          fired_next_s;

    // Select the duration of the phase currently shown by the FSM.
    always_comb begin
        timed_s = 1'b0;
        dur_s   = {CW{1'b0}};
        case (current_state)
            FillingWater: begin timed_s = 1'b1; dur_s = CW'(FILL_CYCLES);  end
            Washing:      begin timed_s = 1'b1; dur_s = CW'(WASH_CYCLES);  end
            Rinsing:      begin timed_s = 1'b1; dur_s = CW'(RINSE_CYCLES); end
            Spinning:     begin timed_s = 1'b1; dur_s = CW'(SPIN_CYCLES);  end
            default:      begin timed_s = 1'b0; dur_s = {CW{1'b0}};        end
        endcase
    end

    // Next count / fired state; a state change restarts timing, and once a
    // phase has fired it stays frozen until the state changes again.
    always_comb begin
        new_phase_s  = (current_state != prev_state_r);
        tick_s       = timed_s & ~Pause & ~(fired_r & ~new_phase_s);
        base_cnt_s   = new_phase_s ? {CW{1'b0}} : cnt_r;
        cnt_next_s   = {CW{1'b0}};
        hit_s        = 1'b0;
        fired_next_s = 1'b0;
        if (timed_s) begin
            cnt_next_s   = base_cnt_s + CW'(tick_s);
            hit_s        = tick_s & (cnt_next_s == dur_s);
            fired_next_s = (new_phase_s ? 1'b0 : fired_r) | hit_s;
        end else begin
            cnt_next_s   = {CW{1'b0}};
            hit_s        = 1'b0;
            fired_next_s = 1'b0;
        end
    end

    // Remaining cycles for the display; forced to zero while in reset so the
    // output reads 0 immediately when RST is asserted.
    always_comb begin
        if (RST) begin
            Remaining = {CW{1'b0}};
        end else if (timed_s) begin
            Remaining = dur_s - base_cnt_s;
        end else begin
            Remaining = {CW{1'b0}};
        end
    end

    // Phase tracking registers and the registered done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_state_r <= IDLE;
            cnt_r        <= {CW{1'b0}};
            fired_r      <= 1'b0;
            DoneFlags    <= Done_None;
        end else begin
            prev_state_r <= current_state;
            cnt_r        <= cnt_next_s;
            fired_r      <= fired_next_s;
            DoneFlags    <= hit_s ? done_flag(current_state) : Done_None;
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer: a stimulus process drives the FSM
// state, Pause and RST, a reference model predicts each cycle's outputs into
// a queue, and a monitor on the falling edge pops and compares.
module tb_wash_phase_timer;

    localparam int TCW = 3;

    logic           CLK;
    logic           RST;
    logic [2:0]     current_state;
    logic           Pause;
    logic [3:0]     DoneFlags;
    logic [TCW-1:0] Remaining;

    wash_phase_timer #(
        .FILL_CYCLES (4),
        .WASH_CYCLES (6),
        .RINSE_CYCLES(3),
        .SPIN_CYCLES (5),
        .CW          (TCW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .current_state(current_state),
        .Pause        (Pause),
        .DoneFlags    (DoneFlags),
        .Remaining    (Remaining)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: phase durations by state, cycles of progress made in
    // the current phase, and the pulse due to appear in the next cycle.
    int         dur_tab [8] = '{0, 4, 6, 3, 5, 0, 0, 0};
    int         elapsed;
    logic [2:0] m_prev;
    logic [3:0] m_pend;
    logic [3:0] last_df;

    logic [6:0] exp_q[$];
    int         n_checks;
    int         n_pass;

    task automatic model_step(input logic [2:0] st, input logic p, input logic r);
        logic [3:0] df_e;
        int         rem_e;
        int         dur;
        dur = dur_tab[st];
        if (r) begin
            df_e    = 4'b0000;
            rem_e   = 0;
            m_prev  = 3'b000;
            elapsed = 0;
            m_pend  = 4'b0000;
        end else begin
            df_e   = m_pend;
            m_pend = 4'b0000;
            if (st != m_prev) elapsed = 0;
            m_prev = st;
            rem_e  = (dur > 0) ? (dur - elapsed) : 0;
            if (dur > 0 && !p && elapsed < dur) begin
                elapsed++;
                if (elapsed == dur) m_pend = 4'b1000 >> (int'(st) - 1);
            end
        end
        last_df = df_e;
        exp_q.push_back({df_e, rem_e[TCW-1:0]});
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic step(input logic [2:0] st, input logic p, input logic r);
        current_state = st;
        Pause         = p;
        RST           = r;
        model_step(st, p, r);
        @(posedge CLK);
        #1;
    endtask

    // Closed-loop FSM: advance to the next phase after each done pulse.
    task automatic run_fsm(input logic [2:0] start);
        logic [2:0] st;
        st = start;
        for (int i = 0; i < 80 && st != 3'b000; i++) begin
            step(st, 1'b0, 1'b0);
            if (last_df != 4'b0000) st = (st == 3'b100) ? 3'b000 : st + 3'd1;
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction.
    always @(negedge CLK) begin : monitor
        logic [6:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (DoneFlags === e[6:3]) n_pass++;
            else $display("FAIL done_flags t=%0t state=%b got %b want %b", $time, current_state, DoneFlags, e[6:3]);
            n_checks++;
            if (Remaining === e[TCW-1:0]) n_pass++;
            else $display("FAIL remaining t=%0t state=%b got %0d want %0d", $time, current_state, Remaining, e[TCW-1:0]);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] st;
        logic       p;
        logic       r;
        n_checks      = 0;
        n_pass        = 0;
        elapsed       = 0;
        m_prev        = 3'b000;
        m_pend        = 4'b0000;
        last_df       = 4'b0000;
        RST           = 1'b1;
        current_state = 3'b010;
        Pause         = 1'b0;
        @(posedge CLK);
        #1;

        // Reset with Washing shown, then idle after release.
        step(3'b010, 1'b0, 1'b1);
        step(3'b010, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 1'b0);

        // Fill runs to completion, then back to idle.
        for (int i = 0; i < 6; i++) step(3'b001, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0);

        // Wash with two paused cycles at E+2..E+3.
        for (int i = 0; i < 11; i++) step(3'b010, (i == 2 || i == 3), 1'b0);
        step(3'b000, 1'b0, 1'b0);

        // Rinse held well past its pulse.
        for (int i = 0; i < 14; i++) step(3'b011, 1'b0, 1'b0);

        // Double wash: back to Washing, then closed loop through Rinse/Spin.
        run_fsm(3'b010);
        step(3'b000, 1'b0, 1'b0);

        // State change in the pulse cycle: pulse completes, wash counts from there.
        for (int i = 0; i < 3; i++) step(3'b011, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(3'b010, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0);

        // Reset asserted mid-cycle in a pulse cycle clears the pulse at once.
        for (int i = 0; i < 4; i++) step(3'b001, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b0);

        // Abort Spinning at E+2, then sit in an invalid state.
        for (int i = 0; i < 2; i++) step(3'b100, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(3'b101, 1'b0, 1'b0);

        // Randomized FSM-like traffic with pauses, jumps and resets.
        st = 3'b001;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            p = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) st = 3'($urandom_range(0, 7));
            step(st, p, r);
            if (last_df != 4'b0000 && st >= 3'b001 && st <= 3'b100)
                st = (st == 3'b100) ? 3'b000 : st + 3'd1;
            else if (st == 3'b000 && $urandom_range(0, 3) == 0)
                st = 3'b001;
        end
        step(3'b000, 1'b0, 1'b0);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Generates the per-phase completion flags that drive the washing-machine controller FSM. Watches the FSM's `current_state` and counts clock cycles spent in each timed phase: FillingWater, Washing, Rinsing and Spinning. When a phase's configured duration elapses, it emits a one-cycle, one-hot `DoneFlags` pulse. It sits directly upstream of the FSM's `DoneFlags` input and closes the state/flag loop. It also exports a remaining-time count for a display.

## Interface
- `FILL_CYCLES`, default 16: active cycles in FillingWater (≥1)
- `WASH_CYCLES`, default 32: active cycles in Washing (≥1)
- `RINSE_CYCLES`, default 24: active cycles in Rinsing (≥1)
- `SPIN_CYCLES`, default 20: active cycles in Spinning (≥1)
- `CW`, default $clog2(max duration + 1): counter/remaining width
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `current_state`  in  3  FSM state: 000 IDLE, 001 FillingWater, 010 Washing, 011 Rinsing, 100 Spinning
- `Pause`  in  1  freeze phase timing (lid open / user pause)
- `DoneFlags`  out  4  registered one-hot done pulse: 1000 fill, 0100 wash, 0010 rinse, 0001 spin, else 0000
- `Remaining`  out  CW  active cycles left in current phase; 0 in IDLE/invalid

## Operation
- Internal registers:
  - `prev_state` (3b): reset IDLE
  - `cnt` (CW): reset 0
  - `fired` (1b): reset 0
  - `DoneFlags`: reset 0000
- Decoded signals:
  - `new_phase` = (`current_state` != `prev_state`); `prev_state` <= `current_state` every cycle.
  - `timed` = state in 001..100; `DUR` = duration selected by state; 0 when untimed.
  - `tick` = `timed` & !`Pause` & !(`fired` & !`new_phase`).
- Per cycle:
  - `cnt_next` = (`new_phase` ? 0 : `cnt`) + `tick`.
  - `fired_next` = (`new_phase` ? 0 : `fired`) | (`tick` & `cnt_next` == `DUR`).
- `DoneFlags` <= flag(`current_state`) when `tick` & `cnt_next` == `DUR`, else 0000. Never more than one bit set.
- After `fired`, the phase is frozen. `cnt` holds at `DUR`, no further pulse, `Remaining` = 0, until the state changes.
- Any state change restarts timing, including a mid-phase jump or the Rinsing→Washing double-wash loop.
- Untimed state (IDLE, 101–111): `cnt` → 0, `fired` → 0, `DoneFlags` = 0000.
- `Remaining` (combinational) = `timed` ? (`DUR` − (`new_phase` ? 0 : `cnt`)) : 0. Unsigned, never negative since `cnt` ≤ `DUR`.

## Timing
- Let E be the first cycle `current_state` shows a timed phase. With `Pause` low throughout, `DoneFlags` is high in exactly cycle E+`DUR` for one cycle.
- Each `Pause`-high cycle inside the phase delays the pulse by one cycle. `Pause` in the pulse cycle does not cancel an already-registered pulse.
- FSM consumes the pulse in cycle E+`DUR`; the new state appears at E+`DUR`+1 and starts a new count there.
- `Remaining`: `DUR` in cycle E, decrements by 1 per non-paused cycle, reaches 0 in cycle E+`DUR`.
- State change in the same cycle as the pulse: the pulse still completes; the new phase counts from that cycle.
- `RST` asserted at any time: all registers are cleared immediately (asynchronously) and the outputs go to 0000 / 0. The first edge after release behaves as if arriving from IDLE.

## Structure
- Shared package `wm_pkg` holds the state encodings (IDLE..Spinning) and done-flag constants (`Done_FillingWater`..`Done_Spinning`). This block and the FSM both import it; the FSM's local copies move there.
- Flat module, no sub-modules. The duration select is a case on state.

## Test plan
Durations for all scenarios: FILL=4, WASH=6, RINSE=3, SPIN=5.
- Reset: `RST`=1 with state=010 → `DoneFlags`=0000, `Remaining`=0. After release with state=000: outputs stay 0.
- Fill: state=001 from cycle E, `Pause`=0 → `DoneFlags`=1000 only in E+4; `Remaining` shows 4,3,2,1,0 over E..E+4.
- Pause: state=010 from E, `Pause`=1 in E+2..E+3 → `DoneFlags`=0100 only in E+8.
- Hold: keep state=011 for 10 cycles after the pulse → single 0010 pulse at E+3, then 0000 with `Remaining`=0.
- Double wash: 011 → 010 at cycle F → timer restarts, 0100 at F+6. Then 010 → 011 → 100 closed-loop with the FSM produces 0010 then 0001 at the correct offsets.
- Abort: `RST` at E+2 of Spinning → outputs 0 asynchronously, no pulse. State=101 afterwards → `DoneFlags`=0000 indefinitely.
